uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, LSB first, line idles high.
- Pairs with the team's uart_transmitter on the same link, using the same CYCLES_PER_SAMPLE baud timing.
- Synchronises the asynchronous rx pin, samples each bit at its mid-point, and presents a received byte with a one-cycle valid pulse.
- Reports framing errors on a separate one-cycle pulse.

Parameters:
- CYCLES_PER_SAMPLE, 10416: clk cycles per bit (100 MHz / 9600 baud). Legal range 4..65535.
- HALF_SAMPLE, CYCLES_PER_SAMPLE/2: cycles from the falling edge to the start-bit mid-point. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on posedge.
- r_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line, idle high.
- o_data  output  8  last correctly framed byte; first received bit in o_data[0].
- o_valid  output  1  one-cycle pulse; o_data updated in the same cycle.
- o_frame_error  output  1  one-cycle pulse; stop bit sampled low.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is synchronous, active-high, on r_reset with clock clk. It dominates all other activity, including mid-frame.
- Reset values: o_data=0x00, o_valid=0, o_frame_error=0, o_busy=0, state=IDLE, counter=0, bit index=0, shift register=0, synchroniser flops=1.
- Synchroniser: 2 flops, giving 2 cycles of latency. All behaviour below refers to the synchronised line rx_s.
- Counter: 16 bits, fixed width. Compare against CYCLES_PER_SAMPLE-1 explicitly; no reliance on overflow.
- IDLE: rx_s==0 -> START with counter cleared.
- START: count to HALF_SAMPLE-1, then sample rx_s.
  - rx_s==0 -> DATA, counter=0, bit index=0.
  - rx_s==1 -> false start (glitch); return to IDLE with no output pulse.
- DATA: count to CYCLES_PER_SAMPLE-1, then sample rx_s into shift[bit index] and increment the bit index.
  - After the 8th sample -> STOP.
- STOP: count to CYCLES_PER_SAMPLE-1, then sample rx_s.
  - rx_s==1: o_data<=shift and o_valid=1 on the next cycle; go to IDLE.
  - rx_s==0: o_frame_error=1 on the next cycle, o_data unchanged; go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line (break) from being decoded as 0x00 frames.
- Outputs are registered. o_valid and o_frame_error are never high together and are never high for more than one cycle.
- Back-to-back frames:
  - Returning to IDLE at the stop-bit mid-point lets a start edge arriving half a bit later be caught.
  - The timing error is at most 1 cycle per frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. A PARITY state sits between DATA and STOP, with one full bit period and a mid-point sample.
  - If the XOR of the 8 data bits and the parity bit is not 0, o_parity_error (output, 1 bit, one-cycle pulse) is asserted together with the stop-bit result.
  - On a parity error o_valid is suppressed and o_data is unchanged.
  - o_parity_error resets to 0.
- Undefined:
  - No PARITY state and no o_parity_error port; the frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - RxState enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default CYCLES_PER_SAMPLE constant, shared with the transmitter.
  - DATA_BITS=8.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1.

Test Plan (CYCLES_PER_SAMPLE=16 in simulation):
- Frame 0xA5: start low for 16 cycles, then bits 1,0,1,0,0,1,0,1 and stop high -> exactly one o_valid pulse, o_data=0xA5, o_frame_error never asserted, o_busy returns to 0.
- Glitch: i_rx low for 3 cycles, then high -> no o_valid or o_frame_error; state back to IDLE; a following 0x3C frame is received correctly.
- Framing error: frame 0x55 with stop bit low, line held low for 60 more cycles -> one o_frame_error pulse, no o_valid, o_data keeps its prior value, no further pulses until the line goes high. A following 0x81 frame yields o_valid with o_data=0x81.
- Back-to-back: frames 0x00 then 0xFF with only the 16-cycle stop bit between them -> two o_valid pulses with o_data=0x00 then 0xFF.
- Reset mid-frame: r_reset for 1 cycle during data bit 3 -> next cycle all outputs are at reset values and o_busy=0. A later 0xC3 frame is received correctly.
- UART_RX_PARITY_EN: 0x07 with parity 1 -> o_valid, o_data=0x07. The same frame with parity 0 -> o_parity_error pulse, no o_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default baud timing.
package uart_pkg;

   localparam int unsigned DATA_BITS             = 8;
   localparam int unsigned CYCLES_PER_SAMPLE_DEF = 10416;
   localparam int unsigned CNT_W                 = 16;
   localparam int unsigned BIT_IDX_W             = 3;
   localparam int unsigned STATE_W               = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver output bundle; o_parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if;

   logic [uart_pkg::DATA_BITS-1:0] o_data;
   logic                           o_valid;
   logic                           o_frame_error;
   logic                           o_busy;
`ifdef UART_RX_PARITY_EN
   logic                           o_parity_error;

   modport master (output o_data, output o_valid, output o_frame_error,
                   output o_busy, output o_parity_error);
   modport slave  (input  o_data, input  o_valid, input  o_frame_error,
                   input  o_busy, input  o_parity_error);
`else
   modport master (output o_data, output o_valid, output o_frame_error,
                   output o_busy);
   modport slave  (input  o_data, input  o_valid, input  o_frame_error,
                   input  o_busy);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic r_reset,
   input  logic i_async,
   output logic o_sync
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (r_reset) begin
         meta_q <= 1'b1;
         o_sync <= 1'b1;
      end else begin
         meta_q <= i_async;
         o_sync <= meta_q;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 framing with an o_parity_error pulse.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CYCLES_PER_SAMPLE = CYCLES_PER_SAMPLE_DEF
) (
   input  logic            clk,
   input  logic            r_reset,
   input  logic            i_rx,
   uart_receiver_if.master rx_if
);

   localparam int unsigned HALF_SAMPLE = CYCLES_PER_SAMPLE / 2;

   localparam logic [CNT_W-1:0]     CNT_BIT_LAST  = CNT_W'(CYCLES_PER_SAMPLE - 1);
   localparam logic [CNT_W-1:0]     CNT_HALF_LAST = CNT_W'(HALF_SAMPLE - 1);
   localparam logic [BIT_IDX_W-1:0] BIT_IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

   localparam logic [STATE_W-1:0] ST_IDLE   = STATE_W'(IDLE);
   localparam logic [STATE_W-1:0] ST_START  = STATE_W'(START);
   localparam logic [STATE_W-1:0] ST_DATA   = STATE_W'(DATA);
   localparam logic [STATE_W-1:0] ST_STOP   = STATE_W'(STOP);
   localparam logic [STATE_W-1:0] ST_BREAK  = STATE_W'(BREAK);
`ifdef UART_RX_PARITY_EN
   localparam logic [STATE_W-1:0] ST_PARITY = STATE_W'(PARITY);
`endif

   logic                 rx_s;
   logic [STATE_W-1:0]   state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic [DATA_BITS-1:0] data_q,    data_d;
   logic                 valid_q,   valid_d;
   logic                 ferr_q,    ferr_d;
   logic                 busy_q,    busy_d;
   logic                 bit_done;
   logic                 parity_bad;
`ifdef UART_RX_PARITY_EN
   logic                 par_q,     par_d;
   logic                 perr_q,    perr_d;
`endif

   uart_rx_sync u_sync (
      .clk     (clk),
      .r_reset (r_reset),
      .i_async (i_rx),
      .o_sync  (rx_s)
   );

   // Register stage for state, datapath and all outputs
   always_ff @(posedge clk) begin
      if (r_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   // Even parity over data plus parity bit must come out zero
`ifdef UART_RX_PARITY_EN
   assign parity_bad = ^{shift_q, par_q};
`else
   assign parity_bad = 1'b0;
`endif

   assign bit_done = (cnt_q == CNT_BIT_LAST);

   // Next-state and datapath; pulses default low so they last one cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + BIT_IDX_W'(1);
               if (bit_idx_q == BIT_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               cnt_d = '0;
`ifdef UART_RX_PARITY_EN
               perr_d = parity_bad;
`endif
               if (rx_s) begin
                  state_d = ST_IDLE;
                  if (!parity_bad) begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end
               end else begin
                  // Held-low line must not be decoded as a stream of 0x00 frames
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign rx_if.o_data        = data_q;
   assign rx_if.o_valid       = valid_q;
   assign rx_if.o_frame_error = ferr_q;
   assign rx_if.o_busy        = busy_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.o_parity_error = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver: serial frames are scored against an event-level model.
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int unsigned CPS  = 16;
   localparam int unsigned HALF = CPS / 2;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = DATA_BITS + 2;
`else
   localparam int unsigned FRAME_BITS = DATA_BITS + 1;
`endif
   // Sync (2) + half start bit + full periods up to the stop-bit mid-point
   localparam int unsigned LATENCY = 2 + HALF + FRAME_BITS * CPS;

   logic clk = 1'b0;
   logic r_reset;
   logic i_rx;

   uart_receiver_if rx_if ();

   uart_receiver #(.CYCLES_PER_SAMPLE(CPS)) dut (
      .clk     (clk),
      .r_reset (r_reset),
      .i_rx    (i_rx),
      .rx_if   (rx_if)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;
   int unsigned last_valid_cyc = 0;
   logic [7:0]  last_good = 8'h00;
   // Event word: {parity_error, frame_error, valid, data}
   logic [10:0] obs_q[$];
   logic [10:0] exp_q[$];
   logic        mon_pe, mon_any, prev_pulse = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Collect output pulses; pulses must be exclusive and single-cycle
   always @(negedge clk) begin
`ifdef UART_RX_PARITY_EN
      mon_pe = rx_if.o_parity_error;
`else
      mon_pe = 1'b0;
`endif
      mon_any = rx_if.o_valid | rx_if.o_frame_error | mon_pe;
      if (prev_pulse === 1'b1)
         check("pulse_width", 32'(mon_any), 32'd0);
      if (mon_any === 1'b1) begin
         obs_q.push_back({mon_pe, rx_if.o_frame_error, rx_if.o_valid,
                          rx_if.o_valid ? rx_if.o_data : 8'h00});
         check("pulse_excl", 32'(rx_if.o_valid & rx_if.o_frame_error), 32'd0);
         if (rx_if.o_valid) last_valid_cyc = cyc;
      end
      prev_pulse = mon_any;
   end

   task automatic idle(input int unsigned n);
      i_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      i_rx = b;
      repeat (CPS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop);
      start_cyc = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ ~par_ok);
`endif
      send_bit(stop);
      if (!stop)       exp_q.push_back({~par_ok, 1'b1, 1'b0, 8'h00});
      else if (par_ok) begin
         exp_q.push_back({3'b001, d});
         last_good = d;
      end else         exp_q.push_back({3'b100, 8'h00});
   endtask

   task automatic drain(input string tag, input logic exp_busy);
      int unsigned n;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < int'(n); i++)
         check($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      check({tag, "_data"}, 32'(rx_if.o_data), 32'(last_good));
      check({tag, "_busy"}, 32'(rx_if.o_busy), 32'(exp_busy));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       stop, par_ok;
      r_reset = 1'b1;
      i_rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data",  32'(rx_if.o_data), 32'h00);
      check("rst_valid", 32'(rx_if.o_valid), 32'd0);
      check("rst_ferr",  32'(rx_if.o_frame_error), 32'd0);
      check("rst_busy",  32'(rx_if.o_busy), 32'd0);
      r_reset = 1'b0;
      idle(4);

      send_frame(8'hA5, 1'b1, 1'b1);
      idle(CPS);
      check("a5_latency", last_valid_cyc - start_cyc, LATENCY);
      drain("a5", 1'b0);

      i_rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(2 * CPS);
      drain("glitch", 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1);
      idle(CPS);
      drain("after_glitch", 1'b0);

      send_frame(8'h55, 1'b1, 1'b0);
      i_rx = 1'b0;
      repeat (60) @(negedge clk);
      drain("ferr", 1'b1);
      idle(2 * CPS);
      drain("ferr_release", 1'b0);
      send_frame(8'h81, 1'b1, 1'b1);
      idle(CPS);
      drain("after_ferr", 1'b0);

      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      idle(CPS);
      drain("b2b", 1'b0);

      // Reset during data bit 3 of 0x5A
      d = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      i_rx = d[3];
      repeat (HALF) @(negedge clk);
      r_reset = 1'b1;
      i_rx    = 1'b1;
      @(negedge clk);
      r_reset = 1'b0;
      check("midrst_data",  32'(rx_if.o_data), 32'h00);
      check("midrst_valid", 32'(rx_if.o_valid), 32'd0);
      check("midrst_ferr",  32'(rx_if.o_frame_error), 32'd0);
      check("midrst_busy",  32'(rx_if.o_busy), 32'd0);
      last_good = 8'h00;
      idle(2 * CPS);
      drain("midrst", 1'b0);
      send_frame(8'hC3, 1'b1, 1'b1);
      idle(CPS);
      drain("after_midrst", 1'b0);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      idle(CPS);
      drain("par_ok", 1'b0);
      send_frame(8'h07, 1'b0, 1'b1);
      idle(CPS);
      drain("par_bad", 1'b0);
`endif

      for (int k = 0; k < 16; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            i_rx = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            idle(2 * CPS);
         end else begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            par_ok = ($urandom_range(0, 3) != 0);
`else
            par_ok = 1'b1;
`endif
            send_frame(d, par_ok, stop);
            if (stop) idle($urandom_range(0, 6));
            else      idle($urandom_range(4, 10));
         end
      end
      idle(2 * CPS);
      drain("random", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
